seg_display_driver: RTL and testbench

- Consumes the 10-bit countdown value (0..1023) produced by the game timer stage and drives the Basys 3 4-digit common-anode seven-segment display.
- Converts binary to BCD with a sequential double-dabble engine, then time-multiplexes the four digits.
- Supports leading-zero blanking, a global blank, and a low-time flash warning.

---
 rtl/seg_pkg.sv | 55 +++++
 rtl/bin2bcd_seq.sv | 69 ++++++
 rtl/seg_display_driver.sv | 96 +++++++++
 tb/tb_seg_display_driver.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the Basys 3 seven-segment driver: cathode and anode
// patterns, conversion FSM encoding, and small decode helpers.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } conv_state_t;

    // Codes 10..15 never come out of the converter; show them as blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] an_select(input logic [1:0] idx);
        case (idx)
            2'd0:    an_select = AN_DIG0;
            2'd1:    an_select = AN_DIG1;
            2'd2:    an_select = AN_DIG2;
            default: an_select = AN_DIG3;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 10-bit binary to 4-digit BCD, one shift per cycle,
// 12-cycle period when start is held high.
module bin2bcd_seq (
    input  logic        clk_65M,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic [15:0] bcd,
    output logic        done
);
    import seg_pkg::*;

    // Handshake: start is sampled only in IDLE (bin captured on that edge);
    // done is a one-cycle pulse on the same edge bcd updates. No backpressure.
    conv_state_t state, state_next;
    logic [9:0]  bin_sr;
    logic [15:0] scratch, scratch_adj;
    logic [3:0]  iter;

    always_ff @(posedge clk_65M or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (iter == 4'd9) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        scratch_adj = scratch;
        for (int k = 0; k < 4; k++) begin
            if (scratch[k*4 +: 4] >= 4'd5) scratch_adj[k*4 +: 4] = scratch[k*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk_65M or negedge reset) begin
        if (!reset) begin
            bin_sr  <= '0;
            scratch <= '0;
            iter    <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == LATCH);
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= bin;
                        scratch <= '0;
                        iter    <= '0;
                    end
                end
                SHIFT: begin
                    {scratch, bin_sr} <= {scratch_adj[14:0], bin_sr, 1'b0};
                    iter              <= iter + 4'd1;
                end
                LATCH:   bcd <= scratch;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seg_display_driver.sv
// Drives the 4-digit common-anode display from a 10-bit count: BCD conversion,
// digit multiplexing, leading-zero blanking, global blank and low-time flash.
module seg_display_driver #(
    parameter int         REFRESH_CYCLES = 65000,
    parameter int         FLASH_CYCLES   = 16250000,
    parameter logic [9:0] WARN_LEVEL     = 10'd10,
    parameter bit         LZ_BLANK       = 1'b1
) (
    input  logic        clk_65M,
    input  logic        reset,
    input  logic [9:0]  value,
    input  logic        blank,
    input  logic        flash_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [15:0] bcd_out,
    output logic        conv_done
);
    import seg_pkg::*;

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [FW-1:0] flash_cnt;
    logic          flash_phase;
    logic [3:0]    nibble;
    logic          lz_hide, flash_off;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    bin2bcd_seq u_bin2bcd (
        .clk_65M (clk_65M),
        .reset   (reset),
        .start   (1'b1),
        .bin     (value),
        .bcd     (bcd_out),
        .done    (conv_done)
    );

    always_ff @(posedge clk_65M or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else begin
            if (refresh_cnt == RW'(REFRESH_CYCLES - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            if (flash_cnt == FW'(FLASH_CYCLES - 1)) begin
                flash_cnt   <= '0;
                flash_phase <= ~flash_phase;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it is zero;
    // the ones digit is never hidden so 0 still shows.
    always_comb begin
        nibble = bcd_out[{digit_idx, 2'b00} +: 4];
        case (digit_idx)
            2'd1:    lz_hide = (bcd_out[15:4] == 12'd0);
            2'd2:    lz_hide = (bcd_out[15:8] == 8'd0);
            2'd3:    lz_hide = (bcd_out[15:12] == 4'd0);
            default: lz_hide = 1'b0;
        endcase
        flash_off = flash_en && (value <= WARN_LEVEL) && flash_phase;
        an_next   = AN_OFF;
        seg_next  = SEG_BLANK;
        if (!blank && !flash_off && !(LZ_BLANK && lz_hide)) begin
            an_next  = an_select(digit_idx);
            seg_next = seg_decode(nibble);
        end
    end

    always_ff @(posedge clk_65M or negedge reset) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// Bench for seg_display_driver: randomized and directed stimulus checked
// against a cycle-count based reference model of the display.
module tb_seg_display_driver;

    localparam int R = 4;
    localparam int F = 64;

    logic        clk_65M = 1'b0;
    logic        reset   = 1'b0;
    logic [9:0]  value   = '0;
    logic        blank   = 1'b0;
    logic        flash_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] bcd_out;
    logic        conv_done;

    int errors = 0;
    int checks = 0;

    seg_display_driver #(
        .REFRESH_CYCLES (R),
        .FLASH_CYCLES   (F)
    ) dut (
        .clk_65M   (clk_65M),
        .reset     (reset),
        .value     (value),
        .blank     (blank),
        .flash_en  (flash_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .bcd_out   (bcd_out),
        .conv_done (conv_done)
    );

    // clock / watchdog
    always #5 clk_65M = ~clk_65M;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // reference model: everything derived from cycles since reset release
    logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int          n, cap_val, shown_val, m_idx, m_ph, m_pow;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_done;
    logic [15:0] exp_bcd;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk_65M or negedge reset) begin
        if (!reset) begin
            n = 0; shown_val = 0; cap_val = 0;
            exp_an = 4'b1111; exp_seg = 7'b1111111; exp_done = 1'b0; exp_bcd = 16'h0000;
        end else begin
            n++;
            m_idx = ((n - 1) / R) % 4;
            m_ph  = ((n - 1) / F) % 2;
            m_pow = (m_idx == 0) ? 1 : (m_idx == 1) ? 10 : (m_idx == 2) ? 100 : 1000;
            if (blank || (flash_en && value <= 10'd10 && m_ph == 1) || (m_idx > 0 && shown_val < m_pow)) begin
                exp_an  = 4'b1111;
                exp_seg = 7'b1111111;
            end else begin
                exp_an  = ~(4'b0001 << m_idx);
                exp_seg = seg_tab[(shown_val / m_pow) % 10];
            end
            if (n % 12 == 1) cap_val = int'(value);
            exp_done = (n % 12 == 0);
            if (n % 12 == 0) shown_val = cap_val;
            exp_bcd = to_bcd(shown_val);
        end
    end

    task automatic test_reset();
        int i;
        reset = 1'b0; value = 10'd500; blank = 1'b0; flash_en = 1'b0;
        repeat (5) @(negedge clk_65M);
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        checks++;
        if (bcd_out !== 16'h0000 || conv_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_bcd bcd_out=%h conv_done=%b want 0000/0", bcd_out, conv_done);
        end
        reset = 1'b1;
        for (i = 0; i < 20; i++) begin
            @(negedge clk_65M);
            if (conv_done === 1'b1) break;
        end
        checks++;
        if (i != 11) begin
            errors++;
            $display("FAIL first_done_latency got cycle %0d want cycle 11", i);
        end
        checks++;
        if (bcd_out !== 16'h0500) begin
            errors++;
            $display("FAIL first_bcd bcd_out=%h want 0500", bcd_out);
        end
    endtask

    task automatic test_digits();
        for (int i = 0; i < 8 * R; i++) begin
            @(negedge clk_65M);
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL digits_500 n=%0d an=%b seg=%b want an=%b seg=%b", n, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_extremes();
        value = 10'd1023;
        repeat (24) @(negedge clk_65M);
        checks++;
        if (bcd_out !== 16'h1023) begin
            errors++;
            $display("FAIL bcd_1023 bcd_out=%h want 1023", bcd_out);
        end
        for (int i = 0; i < 4 * R; i++) begin
            @(negedge clk_65M);
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL digits_1023 n=%0d an=%b seg=%b want an=%b seg=%b", n, an, seg, exp_an, exp_seg);
            end
        end
        value = 10'd0;
        repeat (24) @(negedge clk_65M);
        checks++;
        if (bcd_out !== 16'h0000) begin
            errors++;
            $display("FAIL bcd_0 bcd_out=%h want 0000", bcd_out);
        end
        for (int i = 0; i < 8 * R; i++) begin
            @(negedge clk_65M);
            checks++;
            if (!((an === 4'b1111 && seg === 7'b1111111) || (an === 4'b1110 && seg === 7'b1000000))
                || an !== exp_an) begin
                errors++;
                $display("FAIL zero_single_digit n=%0d an=%b seg=%b want an=%b seg=%b", n, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_midshift();
        int i;
        logic [15:0] prev;
        for (i = 0; i < 30; i++) begin
            @(negedge clk_65M);
            if (conv_done === 1'b1) break;
        end
        checks++;
        if (i == 30) begin
            errors++;
            $display("FAIL midshift_sync no conv_done within 30 cycles");
        end
        prev  = bcd_out;
        value = 10'd520;
        repeat (4) @(negedge clk_65M);
        value = 10'd519;
        for (i = 0; i < 30; i++) begin
            @(negedge clk_65M);
            checks++;
            if (bcd_out !== prev && bcd_out !== 16'h0520) begin
                errors++;
                $display("FAIL midshift_tear bcd_out=%h want %h or 0520", bcd_out, prev);
            end
            if (conv_done === 1'b1) break;
        end
        checks++;
        if (bcd_out !== 16'h0520) begin
            errors++;
            $display("FAIL midshift_first bcd_out=%h want 0520", bcd_out);
        end
        for (i = 0; i < 30; i++) begin
            @(negedge clk_65M);
            checks++;
            if (bcd_out !== 16'h0520 && bcd_out !== 16'h0519) begin
                errors++;
                $display("FAIL midshift_tear2 bcd_out=%h want 0520 or 0519", bcd_out);
            end
            if (conv_done === 1'b1) break;
        end
        checks++;
        if (bcd_out !== 16'h0519 || i != 11) begin
            errors++;
            $display("FAIL midshift_second bcd_out=%h after %0d cycles want 0519 after 11", bcd_out, i);
        end
    endtask

    task automatic test_flash();
        int on_cnt;
        flash_en = 1'b1;
        value    = 10'd5;
        on_cnt   = 0;
        for (int i = 0; i < 5 * F; i++) begin
            @(negedge clk_65M);
            if (an !== 4'b1111) on_cnt++;
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL flash_low n=%0d an=%b seg=%b want an=%b seg=%b", n, an, seg, exp_an, exp_seg);
            end
        end
        checks++;
        if (on_cnt == 0 || on_cnt > 3 * F) begin
            errors++;
            $display("FAIL flash_duty lit cycles=%0d want 1..%0d", on_cnt, 3 * F);
        end
        value = 10'd11;
        for (int i = 0; i < 3 * F; i++) begin
            @(negedge clk_65M);
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL flash_above n=%0d an=%b seg=%b want an=%b seg=%b", n, an, seg, exp_an, exp_seg);
            end
        end
        while (an === 4'b1111) @(negedge clk_65M);
        blank = 1'b1;
        @(negedge clk_65M);
        checks++;
        if (an !== 4'b1111) begin
            errors++;
            $display("FAIL blank_next_cycle an=%b want 1111", an);
        end
        repeat (10) @(negedge clk_65M);
        blank    = 1'b0;
        flash_en = 1'b0;
    endtask

    task automatic test_reset_midshift();
        int i;
        for (i = 0; i < 30; i++) begin
            @(negedge clk_65M);
            if (conv_done === 1'b1) break;
        end
        value = 10'd987;
        repeat (4) @(negedge clk_65M);
        @(posedge clk_65M);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || bcd_out !== 16'h0000 || conv_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset an=%b seg=%b bcd=%h done=%b want 1111/1111111/0000/0", an, seg, bcd_out, conv_done);
        end
        @(negedge clk_65M);
        reset = 1'b1;
        for (i = 0; i < 20; i++) begin
            @(negedge clk_65M);
            checks++;
            if (an !== exp_an || seg !== exp_seg || conv_done !== exp_done || bcd_out !== exp_bcd) begin
                errors++;
                $display("FAIL restart n=%0d an=%b seg=%b done=%b bcd=%h want %b %b %b %h",
                         n, an, seg, conv_done, bcd_out, exp_an, exp_seg, exp_done, exp_bcd);
            end
        end
        checks++;
        if (bcd_out !== 16'h0987) begin
            errors++;
            $display("FAIL restart_bcd bcd_out=%h want 0987", bcd_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0)
                value = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 31) == 0) blank = ~blank;
            if ($urandom_range(0, 63) == 0) flash_en = ~flash_en;
            @(negedge clk_65M);
            checks++;
            if (an !== exp_an || seg !== exp_seg || conv_done !== exp_done || bcd_out !== exp_bcd || dp !== 1'b1) begin
                errors++;
                $display("FAIL random n=%0d an=%b seg=%b done=%b bcd=%h want %b %b %b %h",
                         n, an, seg, conv_done, bcd_out, exp_an, exp_seg, exp_done, exp_bcd);
            end
        end
        blank = 1'b0;
        flash_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_digits();
        test_extremes();
        test_midshift();
        test_flash();
        test_reset_midshift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
